// File: rtl/cmp_sort_ctrl_pkg.sv
// Shared definitions for the four-entry sort controller: state encoding,
// the sort schedule length and the compare-pair table.
package cmp_sort_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam int unsigned SORT_STEPS = 6;
  localparam int unsigned STEP_W     = 3;
  localparam int unsigned IDX_W      = 2;

  // Lower index of the pair exchanged at each step of the 4-entry bubble network
  function automatic logic [IDX_W-1:0] pair_idx(input logic [STEP_W-1:0] step);
    case (step)
      3'd0:    pair_idx = 2'd0;
      3'd1:    pair_idx = 2'd1;
      3'd2:    pair_idx = 2'd2;
      3'd3:    pair_idx = 2'd0;
      3'd4:    pair_idx = 2'd1;
      default: pair_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmp_sort_ctrl_compare.sv
// Combinational magnitude comparator: AGEB = (A >= B), unsigned.
module Compare #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         AGEB
);

  assign AGEB = (A >= B);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Loads four words, sorts them ascending with one shared comparator over six
// compare-exchange steps, then streams them out on four consecutive beats.
module cmp_sort_ctrl
  import cmp_sort_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             LoadEn,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Start,
  output logic [2:0]       Count,
  output logic             Busy,
  output logic [WIDTH-1:0] DataOut,
  output logic             OutValid,
  output logic             Done
);

  logic [1:0]        state, state_d;
  logic [2:0]        count_d;
  logic [STEP_W-1:0] step, step_d;
  logic [IDX_W-1:0]  oidx, oidx_d;
  logic [WIDTH-1:0]  entry   [4];
  logic [WIDTH-1:0]  entry_d [4];
  logic [WIDTH-1:0]  data_out_d;
  logic              out_valid_d, done_d, busy_d;

  logic [IDX_W-1:0]  lo_idx, hi_idx;
  logic              ageb;

  assign lo_idx = pair_idx(step);
  assign hi_idx = lo_idx + 2'd1;

  Compare #(.W(WIDTH)) u_compare (
    .A    (entry[hi_idx]),
    .B    (entry[lo_idx]),
    .AGEB (ageb)
  );

  // State and registered outputs
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state    <= ST_IDLE;
      Count    <= '0;
      step     <= '0;
      oidx     <= '0;
      Busy     <= 1'b0;
      DataOut  <= '0;
      OutValid <= 1'b0;
      Done     <= 1'b0;
      for (int i = 0; i < 4; i++) entry[i] <= '0;
    end else begin
      state    <= state_d;
      Count    <= count_d;
      step     <= step_d;
      oidx     <= oidx_d;
      Busy     <= busy_d;
      DataOut  <= data_out_d;
      OutValid <= out_valid_d;
      Done     <= done_d;
      entry    <= entry_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    count_d     = Count;
    step_d      = step;
    oidx_d      = oidx;
    entry_d     = entry;
    data_out_d  = '0;
    out_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state)
      ST_IDLE: begin
        // Start is judged against the pre-load count
        if (Start && Count == 3'(DEPTH)) begin
          state_d = ST_SORT;
          step_d  = '0;
        end
        if (LoadEn && Count < 3'(DEPTH)) begin
          entry_d[Count[1:0]] = DataIn;
          count_d             = Count + 3'd1;
        end
      end
      ST_SORT: begin
        // Strict less-than swap keeps equal words in place
        if (!ageb) begin
          entry_d[lo_idx] = entry[hi_idx];
          entry_d[hi_idx] = entry[lo_idx];
        end
        if (step == STEP_W'(SORT_STEPS - 1)) begin
          state_d = ST_OUT;
          oidx_d  = '0;
        end else begin
          step_d = step + 3'd1;
        end
      end
      ST_OUT: begin
        data_out_d  = entry[oidx];
        out_valid_d = 1'b1;
        if (oidx == 2'd3) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          count_d = '0;
        end else begin
          oidx_d = oidx + 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl with a scoreboard of expected output beats.
module tb_cmp_sort_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       LoadEn = 1'b0;
  logic [7:0] DataIn = '0;
  logic       Start = 1'b0;
  logic [2:0] Count;
  logic       Busy;
  logic [7:0] DataOut;
  logic       OutValid;
  logic       Done;

  int passed = 0;
  int total  = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mdl   [$];
  int beat = 0;

  always #5 Clk = ~Clk;

  cmp_sort_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .LoadEn(LoadEn), .DataIn(DataIn), .Start(Start),
    .Count(Count), .Busy(Busy), .DataOut(DataOut), .OutValid(OutValid), .Done(Done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Output monitor: pops the scoreboard on every valid beat
  always @(negedge Clk) begin
    if (Rst) begin
      beat = 0;
    end else if (OutValid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 32'(DataOut), 32'hDEAD);
      end else begin
        check("data_out", 32'(DataOut), 32'(exp_q.pop_front()));
      end
      check("done_on_beat", 32'(Done), 32'(beat == 3));
      beat = (beat + 1) % 4;
    end else begin
      check("idle_data_zero", 32'(DataOut), 32'h0);
      check("idle_done_low", 32'(Done), 32'h0);
    end
  end

  task automatic load(input logic [7:0] v);
    @(negedge Clk);
    LoadEn = 1'b1;
    DataIn = v;
    @(posedge Clk);
    #1;
    LoadEn = 1'b0;
    if (mdl.size() < 4) mdl.push_back(v);
  endtask

  // Drives Start for one edge; returns #1 after that edge
  task automatic start_pulse();
    logic [7:0] s [4];
    logic [7:0] t;
    @(negedge Clk);
    Start = 1'b1;
    if (mdl.size() == 4) begin
      for (int i = 0; i < 4; i++) s[i] = mdl[i];
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3 - i; j++)
          if (s[j] > s[j+1]) begin
            t = s[j]; s[j] = s[j+1]; s[j+1] = t;
          end
      for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);
      mdl.delete();
    end
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    bit got = 0;
    n = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(posedge Clk);
      #1;
      n++;
      if (Done) got = 1;
    end
    if (!got) check("done_timeout", 32'(Done), 32'h1);
  endtask

  int n;

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    check("rst_count", 32'(Count), 32'h0);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_valid", 32'(OutValid), 32'h0);
    check("rst_dout", 32'(DataOut), 32'h0);
    @(negedge Clk);
    Rst = 1'b0;

    // Basic sort and latency
    load(8'h99); load(8'h6D); load(8'hA5); load(8'h45);
    check("count_full", 32'(Count), 32'h4);
    start_pulse();
    check("busy_after_start", 32'(Busy), 32'h1);
    wait_done(n);
    check("latency", 32'(n), 32'd10);
    check("count_after_done", 32'(Count), 32'h0);

    // Equal values
    load(8'h25); load(8'h25); load(8'hE8); load(8'h00);
    start_pulse();
    wait_done(n);
    check("latency_eq", 32'(n), 32'd10);

    // Start with only three entries is ignored
    load(8'h30); load(8'h10); load(8'h20);
    start_pulse();
    check("short_start_busy", 32'(Busy), 32'h0);
    repeat (3) @(posedge Clk);
    #1;
    check("short_start_busy_later", 32'(Busy), 32'h0);
    check("short_count", 32'(Count), 32'h3);
    load(8'h05);
    start_pulse();
    wait_done(n);
    check("latency_4th", 32'(n), 32'd10);

    // Overfill saturates
    for (int i = 1; i <= 6; i++) load(8'(i));
    check("count_sat", 32'(Count), 32'h4);
    start_pulse();
    wait_done(n);

    // Reset during sort step 3
    load(8'hF0); load(8'h0F); load(8'h77); load(8'h11);
    start_pulse();
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1'b1;
    #1;
    exp_q.delete();
    mdl.delete();
    check("midrst_busy", 32'(Busy), 32'h0);
    check("midrst_count", 32'(Count), 32'h0);
    check("midrst_valid", 32'(OutValid), 32'h0);
    check("midrst_done", 32'(Done), 32'h0);
    check("midrst_dout", 32'(DataOut), 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    start_pulse();
    check("post_rst_start_ignored", 32'(Busy), 32'h0);
    load(8'h80); load(8'h7F); load(8'h01); load(8'hFE);
    start_pulse();
    wait_done(n);
    check("latency_post_rst", 32'(n), 32'd10);

    // LoadEn and Start during OUT are ignored
    load(8'h44); load(8'h33); load(8'h22); load(8'h11);
    start_pulse();
    repeat (7) @(posedge Clk);
    #1;
    check("in_out_valid", 32'(OutValid), 32'h1);
    LoadEn = 1'b1;
    Start  = 1'b1;
    DataIn = 8'hFF;
    @(posedge Clk);
    #1;
    LoadEn = 1'b0;
    Start  = 1'b0;
    check("out_count_held", 32'(Count), 32'h4);
    wait_done(n);
    @(posedge Clk);
    #1;
    check("out_count_zero", 32'(Count), 32'h0);
    check("out_busy_low", 32'(Busy), 32'h0);

    repeat (3) @(posedge Clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
